// File: rtl/controller_fsm_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, instruction
// field encodings, PSR bit positions, branch conditions and result selects.
// Instruction layout: [15:12] opcode, [11:8] rdest/cond, [7:4] ext, [3:0] rsrc/imm.
package controller_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Primary opcodes (instr[15:12]); the immediate ALU opcodes reuse the
  // register-form extended-opcode values so alu_cond is the same code either way.
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_ADDCI = 4'h7;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_SUBCI = 4'hA;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;

  // Extended opcodes (instr[7:4]) under OP_REG
  localparam logic [3:0] EXT_AND  = 4'h1;
  localparam logic [3:0] EXT_OR   = 4'h2;
  localparam logic [3:0] EXT_XOR  = 4'h3;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_ADDU = 4'h6;
  localparam logic [3:0] EXT_ADDC = 4'h7;
  localparam logic [3:0] EXT_SUB  = 4'h9;
  localparam logic [3:0] EXT_SUBC = 4'hA;
  localparam logic [3:0] EXT_MOV  = 4'hD;

  // Extended opcodes under OP_SHIFT
  localparam logic [3:0] EXT_LSHI_L = 4'h0;
  localparam logic [3:0] EXT_LSHI_R = 4'h1;
  localparam logic [3:0] EXT_LSH    = 4'h4;

  // Extended opcodes under OP_MEM
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  // PSR bit positions
  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  // Branch / jump condition codes (instr[11:8])
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_UC = 4'hE;

  // choose_result encodings for the result mux
  localparam logic [1:0] CHOOSE_ALU   = 2'b00;
  localparam logic [1:0] CHOOSE_SHIFT = 2'b01;
  localparam logic [1:0] CHOOSE_IMM   = 2'b10;
  localparam logic [1:0] CHOOSE_LINK  = 2'b11;

  // Instruction classes the FSM cares about
  typedef enum logic [3:0] {
    K_NOP, K_ALU_R, K_ALU_I, K_SHIFT_R, K_SHIFT_I,
    K_LOAD, K_STOR, K_BCOND, K_JCOND, K_JAL
  } kind_e;

  function automatic logic is_alu_code(input logic [3:0] c);
    return c inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU,
                     EXT_ADDC, EXT_SUB, EXT_SUBC, EXT_MOV};
  endfunction

  function automatic logic is_logical_imm(input logic [15:0] instr);
    return instr[15:12] inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  // Anything not recognised falls out as K_NOP
  function automatic kind_e decode_kind(input logic [15:0] instr);
    logic [3:0] op;
    logic [3:0] ext;
    kind_e      k;
    op  = instr[15:12];
    ext = instr[7:4];
    k   = K_NOP;
    if (op == OP_REG) begin
      if (is_alu_code(ext)) k = K_ALU_R;
    end else if (op == OP_SHIFT) begin
      if (ext == EXT_LSH) k = K_SHIFT_R;
      else if (ext == EXT_LSHI_L || ext == EXT_LSHI_R) k = K_SHIFT_I;
    end else if (op == OP_MEM) begin
      case (ext)
        EXT_LOAD:  k = K_LOAD;
        EXT_STOR:  k = K_STOR;
        EXT_JAL:   k = K_JAL;
        EXT_JCOND: k = K_JCOND;
        default:   k = K_NOP;
      endcase
    end else if (op == OP_BCOND) begin
      k = K_BCOND;
    end else if (is_alu_code(op)) begin
      k = K_ALU_I;
    end
    return k;
  endfunction

endpackage

// File: rtl/controller_fsm_cond_eval.sv
// Condition evaluator: maps PSR flags and a 4-bit condition code to a taken flag.
// Macro CONTROLLER_FSM_COND_BRANCH_EN enables the full condition table; without
// it only the unconditional code is taken and the PSR is ignored.
module controller_fsm_cond_eval
  import controller_fsm_pkg::*;
(
  input  logic [7:0] psr,
  input  logic [3:0] cond,
  output logic       taken
);

`ifdef CONTROLLER_FSM_COND_BRANCH_EN
  logic unused_psr;
  assign unused_psr = ^psr[5:1];

  // Full condition table against the current flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = psr[PSR_Z];
      COND_NE: taken = ~psr[PSR_Z];
      COND_CS: taken = psr[PSR_C];
      COND_CC: taken = ~psr[PSR_C];
      COND_GT: taken = psr[PSR_N];
      COND_LE: taken = ~psr[PSR_N];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
`else
  logic unused_psr;
  assign unused_psr = ^psr;

  // Only the unconditional code is taken
  always_comb begin
    taken = (cond == COND_UC);
  end
`endif

endmodule

// File: rtl/controller_fsm.sv
// Multi-cycle controller FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Optional macro CONTROLLER_FSM_COND_BRANCH_EN (see controller_fsm_cond_eval).
// Outputs are decoded from the current state and the latched instruction; reset
// forces every output low in the same cycle it is asserted.
// Memory handshake: mem_req is held high for as long as the FSM waits; the
// access completes in the cycle where mem_req=1 and mem_ready=1, and the FSM
// moves on at the following edge. No enable fires while waiting.
module controller_fsm
  import controller_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [7:0]  psr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        next_instruction,
  output logic        pc_en,
  output logic        psr_en,
  output logic        update_address,
  output logic        store_reg,
  output logic        write_data,
  output logic        reg_write,
  output logic        zero_extend,
  output logic        pc_instruction,
  output logic        src_b,
  output logic        result_en,
  output logic        immediate_reg_en,
  output logic [3:0]  alu_cond,
  output logic [3:0]  shifter_control,
  output logic [3:0]  shift_amt,
  output logic [1:0]  choose_result,
  output logic        jump_en,
  output logic        branch_en,
  output logic        jal_en,
  output logic [2:0]  state
);

  state_e state_q, state_d;
  kind_e  kind;
  logic   cond_taken;

  assign kind  = decode_kind(instr);
  assign state = state_q;

  controller_fsm_cond_eval cond_eval (
    .psr   (psr),
    .cond  (instr[11:8]),
    .taken (cond_taken)
  );

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; illegal encodings fall back to FETCH
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (kind)
          K_ALU_R, K_ALU_I, K_SHIFT_R, K_SHIFT_I, K_JAL: state_d = ST_WB;
          K_LOAD, K_STOR:                                state_d = ST_MEM;
          default:                                       state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)          state_d = ST_MEM;
        else if (kind == K_LOAD) state_d = ST_WB;
        else                     state_d = ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything defaults low and reset overrides all states
  always_comb begin
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    next_instruction = 1'b0;
    pc_en            = 1'b0;
    psr_en           = 1'b0;
    update_address   = 1'b0;
    store_reg        = 1'b0;
    write_data       = 1'b0;
    reg_write        = 1'b0;
    zero_extend      = 1'b0;
    pc_instruction   = 1'b0;
    src_b            = 1'b0;
    result_en        = 1'b0;
    immediate_reg_en = 1'b0;
    alu_cond         = 4'h0;
    shifter_control  = 4'h0;
    shift_amt        = 4'h0;
    choose_result    = CHOOSE_ALU;
    jump_en          = 1'b0;
    branch_en        = 1'b0;
    jal_en           = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req        = 1'b1;
          update_address = 1'b1;
          if (mem_ready) begin
            next_instruction = 1'b1;
            pc_en            = 1'b1;
          end
        end
        ST_DECODE: begin
          immediate_reg_en = 1'b1;
          zero_extend      = is_logical_imm(instr);
        end
        ST_EXEC: begin
          case (kind)
            K_ALU_R, K_ALU_I: begin
              alu_cond      = (kind == K_ALU_R) ? instr[7:4] : instr[15:12];
              src_b         = (kind == K_ALU_R);
              result_en     = 1'b1;
              psr_en        = 1'b1;
              choose_result = CHOOSE_ALU;
            end
            K_SHIFT_R, K_SHIFT_I: begin
              shifter_control = instr[7:4];
              shift_amt       = instr[3:0];
              src_b           = (kind == K_SHIFT_R);
              result_en       = 1'b1;
              choose_result   = CHOOSE_SHIFT;
            end
            K_BCOND: begin
              if (cond_taken) begin
                pc_en          = 1'b1;
                branch_en      = 1'b1;
                pc_instruction = 1'b1;
              end
            end
            K_JCOND: begin
              if (cond_taken) begin
                pc_en   = 1'b1;
                jump_en = 1'b1;
              end
            end
            K_JAL: begin
              pc_en         = 1'b1;
              jal_en        = 1'b1;
              result_en     = 1'b1;
              choose_result = CHOOSE_LINK;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req        = 1'b1;
          update_address = 1'b0;
          mem_we         = (kind == K_STOR);
          store_reg      = (kind == K_STOR);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          write_data = (kind != K_LOAD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_fsm.sv
// Testbench for controller_fsm: per-instruction cycle traces built from the
// instruction-set rules, a vector table, random instructions, and hand-written
// reset / illegal-state sequences.
module tb_controller_fsm;
  import controller_fsm_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [7:0]  psr;
  logic        mem_ready;
  logic        mem_req, mem_we, next_instruction, pc_en, psr_en;
  logic        update_address, store_reg, write_data, reg_write;
  logic        zero_extend, pc_instruction, src_b, result_en, immediate_reg_en;
  logic [3:0]  alu_cond, shifter_control, shift_amt;
  logic [1:0]  choose_result;
  logic        jump_en, branch_en, jal_en;
  logic [2:0]  state;

  always #5 clk = ~clk;

  controller_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .psr(psr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .next_instruction(next_instruction),
    .pc_en(pc_en), .psr_en(psr_en), .update_address(update_address),
    .store_reg(store_reg), .write_data(write_data), .reg_write(reg_write),
    .zero_extend(zero_extend), .pc_instruction(pc_instruction), .src_b(src_b),
    .result_en(result_en), .immediate_reg_en(immediate_reg_en),
    .alu_cond(alu_cond), .shifter_control(shifter_control), .shift_amt(shift_amt),
    .choose_result(choose_result), .jump_en(jump_en), .branch_en(branch_en),
    .jal_en(jal_en), .state(state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- observed-output record ----------------
  typedef struct packed {
    logic [2:0] st;
    logic mem_req, mem_we, next_instruction, pc_en, psr_en, update_address;
    logic store_reg, write_data, reg_write, zero_extend, pc_instruction;
    logic src_b, result_en, immediate_reg_en, jump_en, branch_en, jal_en;
    logic [3:0] alu_cond, shifter_control, shift_amt;
    logic [1:0] choose_result;
  } outs_t;

  function automatic outs_t idle(input logic [2:0] s);
    outs_t o;
    o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic outs_t fetch_wait();
    outs_t o;
    o = idle(3'd0);
    o.mem_req = 1'b1;
    o.update_address = 1'b1;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.st = state; o.mem_req = mem_req; o.mem_we = mem_we;
    o.next_instruction = next_instruction; o.pc_en = pc_en; o.psr_en = psr_en;
    o.update_address = update_address; o.store_reg = store_reg;
    o.write_data = write_data; o.reg_write = reg_write;
    o.zero_extend = zero_extend; o.pc_instruction = pc_instruction;
    o.src_b = src_b; o.result_en = result_en; o.immediate_reg_en = immediate_reg_en;
    o.jump_en = jump_en; o.branch_en = branch_en; o.jal_en = jal_en;
    o.alu_cond = alu_cond; o.shifter_control = shifter_control;
    o.shift_amt = shift_amt; o.choose_result = choose_result;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];
  logic        mr_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction classes, from the instruction-set table as mask/match patterns
  localparam int T_NOP = 0, T_ALU_R = 1, T_ALU_I = 2, T_SH_R = 3, T_SH_I = 4;
  localparam int T_LOAD = 5, T_STOR = 6, T_BCOND = 7, T_JCOND = 8, T_JAL = 9;
  typedef struct { logic [15:0] mask; logic [15:0] match; int kind; } pat_t;
  pat_t pats[$];

  task automatic build_patterns();
    logic [3:0] alu_codes[9];
    alu_codes = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hD};
    for (int i = 0; i < 9; i++) begin
      pats.push_back('{16'hF0F0, {8'h00, alu_codes[i], 4'h0}, T_ALU_R});
      pats.push_back('{16'hF000, {alu_codes[i], 12'h000}, T_ALU_I});
    end
    pats.push_back('{16'hF0F0, 16'h8040, T_SH_R});
    pats.push_back('{16'hF0F0, 16'h8000, T_SH_I});
    pats.push_back('{16'hF0F0, 16'h8010, T_SH_I});
    pats.push_back('{16'hF0F0, 16'h4000, T_LOAD});
    pats.push_back('{16'hF0F0, 16'h4040, T_STOR});
    pats.push_back('{16'hF0F0, 16'h4080, T_JAL});
    pats.push_back('{16'hF0F0, 16'h40C0, T_JCOND});
    pats.push_back('{16'hF000, 16'hC000, T_BCOND});
  endtask

  function automatic int classify(input logic [15:0] ins);
    foreach (pats[i]) if ((ins & pats[i].mask) == pats[i].match) return pats[i].kind;
    return T_NOP;
  endfunction

  // Condition rules: Z=bit6, C=bit0, N=bit7; 0 EQ,1 NE,2 CS,3 CC,6 GT,7 LE,14 UC
  function automatic bit ref_taken(input logic [3:0] c, input logic [7:0] p);
`ifdef CONTROLLER_FSM_COND_BRANCH_EN
    case (c)
      4'd0:  return p[6];
      4'd1:  return !p[6];
      4'd2:  return p[0];
      4'd3:  return !p[0];
      4'd6:  return p[7];
      4'd7:  return !p[7];
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (c == 4'd14);
`endif
  endfunction

  function automatic void push(input outs_t o, input logic mr);
    exp_q.push_back(o);
    mr_q.push_back(mr);
  endfunction

  function automatic void push_wb(input logic wd);
    outs_t o;
    o = idle(3'd4);
    o.reg_write = 1'b1;
    o.write_data = wd;
    push(o, 1'b0);
  endfunction

  // Builds the cycle-by-cycle trace of one instruction
  function automatic void model(input logic [15:0] ins, input logic [7:0] p,
                                input int fw, input int mw);
    outs_t o;
    int k;
    logic [3:0] op, ex;
    k  = classify(ins);
    op = ins[15:12];
    ex = ins[7:4];
    exp_q.delete();
    mr_q.delete();
    o = fetch_wait();
    for (int i = 0; i < fw; i++) push(o, 1'b0);
    o.next_instruction = 1'b1;
    o.pc_en = 1'b1;
    push(o, 1'b1);
    o = idle(3'd1);
    o.immediate_reg_en = 1'b1;
    o.zero_extend = (k == T_ALU_I) && (op inside {4'h1, 4'h2, 4'h3});
    push(o, 1'b0);
    o = idle(3'd2);
    case (k)
      T_ALU_R, T_ALU_I: begin
        o.alu_cond = (k == T_ALU_R) ? ex : op;
        o.src_b = (k == T_ALU_R);
        o.result_en = 1'b1;
        o.psr_en = 1'b1;
        push(o, 1'b0);
        push_wb(1'b1);
      end
      T_SH_R, T_SH_I: begin
        o.shifter_control = ex;
        o.shift_amt = ins[3:0];
        o.src_b = (k == T_SH_R);
        o.result_en = 1'b1;
        o.choose_result = 2'b01;
        push(o, 1'b0);
        push_wb(1'b1);
      end
      T_LOAD, T_STOR: begin
        push(o, 1'b0);
        o = idle(3'd3);
        o.mem_req = 1'b1;
        o.mem_we = (k == T_STOR);
        o.store_reg = (k == T_STOR);
        for (int i = 0; i < mw; i++) push(o, 1'b0);
        push(o, 1'b1);
        if (k == T_LOAD) push_wb(1'b0);
      end
      T_BCOND: begin
        if (ref_taken(ins[11:8], p)) begin
          o.pc_en = 1'b1; o.branch_en = 1'b1; o.pc_instruction = 1'b1;
        end
        push(o, 1'b0);
      end
      T_JCOND: begin
        if (ref_taken(ins[11:8], p)) begin
          o.pc_en = 1'b1; o.jump_en = 1'b1;
        end
        push(o, 1'b0);
      end
      T_JAL: begin
        o.pc_en = 1'b1; o.jal_en = 1'b1; o.result_en = 1'b1; o.choose_result = 2'b11;
        push(o, 1'b0);
        push_wb(1'b1);
      end
      default: push(o, 1'b0);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  int lat, rw_cnt, pe_cnt, mem_cnt;
  bit seen_other, returned;

  task automatic step(input logic mr);
    @(negedge clk);
    mem_ready = mr;
    #1;
  endtask

  function automatic void track(input outs_t o);
    if (o.reg_write) rw_cnt++;
    if (o.psr_en) pe_cnt++;
    if (o.st == 3'd3 && o.mem_req) mem_cnt++;
    if (!returned) begin
      if (o.st != 3'd0) seen_other = 1'b1;
      else if (seen_other) returned = 1'b1;
      if (!returned) lat++;
    end
  endfunction

  task automatic run_instr(input string nm, input logic [15:0] ins, input logic [7:0] p,
                           input int fw, input int mw, input int exp_lat);
    outs_t got;
    outs_t want;
    logic mr;
    model(ins, p, fw, mw);
    if (exp_lat < 0) exp_lat = exp_q.size();
    lat = 0; rw_cnt = 0; pe_cnt = 0; mem_cnt = 0;
    seen_other = 1'b0; returned = 1'b0;
    instr = ins;
    psr = p;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      mr = mr_q.pop_front();
      step(mr);
      got = sample();
      track(got);
      check(nm, got, want);
    end
    step(1'b0);
    got = sample();
    track(got);
    check({nm, " end"}, got, fetch_wait());
    check({nm, " lat"}, lat, exp_lat);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [15:0] ins;
    logic [7:0]  p;
    int          fw;
    int          mw;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  initial begin
    outs_t o;
    logic [15:0] r;
    int pi;

    build_patterns();
    vecs.push_back('{"add",      16'h0152, 8'h00, 0, 0, 4});
    vecs.push_back('{"sub",      16'h0192, 8'hFF, 1, 0, 5});
    vecs.push_back('{"addi",     16'h5307, 8'h00, 0, 0, 4});
    vecs.push_back('{"andi",     16'h11FF, 8'h00, 0, 0, 4});
    vecs.push_back('{"lsh",      16'h8142, 8'h00, 0, 0, 4});
    vecs.push_back('{"lshi",     16'h8113, 8'h00, 2, 0, 6});
    vecs.push_back('{"load",     16'h4102, 8'h00, 0, 0, 5});
    vecs.push_back('{"load_w3",  16'h4102, 8'h00, 0, 3, 8});
    vecs.push_back('{"load_fw",  16'h4102, 8'h00, 2, 1, 8});
    vecs.push_back('{"stor",     16'h4142, 8'h00, 0, 0, 4});
    vecs.push_back('{"stor_w2",  16'h4142, 8'h00, 0, 2, 6});
    vecs.push_back('{"beq_z1",   16'hC005, 8'h40, 0, 0, 3});
    vecs.push_back('{"beq_z0",   16'hC005, 8'h00, 0, 0, 3});
    vecs.push_back('{"buc",      16'hCE05, 8'h00, 0, 0, 3});
    vecs.push_back('{"bne_z0",   16'hC105, 8'h00, 0, 0, 3});
    vecs.push_back('{"juc",      16'h4EC3, 8'h00, 0, 0, 3});
    vecs.push_back('{"jeq_z1",   16'h40C3, 8'h40, 0, 0, 3});
    vecs.push_back('{"jal",      16'h4183, 8'h00, 0, 0, 4});
    vecs.push_back('{"undef_b",  16'hB123, 8'hFF, 0, 0, 3});
    vecs.push_back('{"undef_f",  16'hF000, 8'h00, 0, 0, 3});
    vecs.push_back('{"undef_r0", 16'h0000, 8'h00, 0, 0, 3});

    // reset with mem_ready=1: reset wins, all outputs low, FETCH
    reset = 1'b1; mem_ready = 1'b1; instr = 16'h0152; psr = 8'h00;
    @(posedge clk);
    step(1'b1);
    check("reset outputs", sample(), idle(3'd0));
    step(1'b1);
    check("reset priority", sample(), idle(3'd0));
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("after reset", sample(), fetch_wait());

    // table-driven vectors
    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].ins, vecs[i].p, vecs[i].fw, vecs[i].mw, vecs[i].lat);
      if (vecs[i].name == "add") begin
        check("add reg_write pulses", rw_cnt, 1);
        check("add psr_en pulses", pe_cnt, 1);
      end
      if (vecs[i].name == "load_w3") begin
        check("load_w3 mem_req cycles", mem_cnt, 4);
        check("load_w3 reg_write pulses", rw_cnt, 1);
      end
      if (vecs[i].name == "stor") check("stor no writeback", rw_cnt, 0);
    end

    // randomized instructions against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        pi = $urandom_range(0, pats.size() - 1);
        r = 16'($urandom);
        r = (pats[pi].match & pats[pi].mask) | (r & ~pats[pi].mask);
      end else begin
        r = 16'($urandom);
      end
      run_instr("rand", r, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    // reset while STOR waits in MEM
    instr = 16'h4142;
    psr = 8'h00;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("rst_stor in mem", {state, mem_we}, {3'd3, 1'b1});
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_stor gated", sample(), idle(3'd3));
    step(1'b1);
    check("rst_stor fetch", sample(), idle(3'd0));
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst_stor released", sample(), fetch_wait());
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      o = sample();
      check("rst_stor no pulse", {o.st, o.reg_write, o.mem_we, o.pc_en}, {3'd0, 3'b000});
    end

    // illegal state encoding
    @(negedge clk);
    mem_ready = 1'b1;
    force dut.state_q = state_e'(3'b111);
    #1;
    check("illegal outputs", sample(), idle(3'b111));
    mem_ready = 1'b0;
    #1;
    release dut.state_q;
    step(1'b0);
    check("illegal recover", sample(), fetch_wait());

    // a normal instruction still runs after recovery
    run_instr("post_illegal_add", 16'h0152, 8'h00, 0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controller_fsm.md
CONTROLLER_FSM -- requirements
Module: controller_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have: instr  in  16  latched instruction; psr  in  8  PSR flags; mem_ready  in  1  memory access complete.
REQ-003 SHALL have: mem_req  out  1  memory access request; mem_we  out  1  memory write strobe.
REQ-004 SHALL have: next_instruction  out  1  instruction-register load; pc_en  out  1  PC load; psr_en  out  1  PSR load.
REQ-005 SHALL have: update_address  out  1  address from PC (1) or register (0); store_reg  out  1  store data from register.
REQ-006 SHALL have: write_data  out  1  register-file writeback from result (1) or memory (0); reg_write  out  1  register-file write.
REQ-007 SHALL have: zero_extend, pc_instruction, src_b, result_en, immediate_reg_en  out  1 each  datapath selects and enables.
REQ-008 SHALL have: alu_cond, shifter_control, shift_amt  out  4 each; choose_result  out  2; jump_en, branch_en, jal_en  out  1 each.
REQ-009 SHALL have: state  out  3  current FSM state, for debug.

Function
REQ-010 States SHALL be FETCH, DECODE, EXEC, MEM, WB, each encoded in 3 bits.
REQ-011 FETCH: mem_req=1 and update_address=1.
- Holds while mem_ready=0.
- On mem_ready=1: next_instruction=1 and pc_en=1 (PC+1) for one cycle, then go to DECODE.
REQ-012 DECODE: immediate_reg_en=1 for one cycle.
- zero_extend=1 for logical immediates; 0 otherwise.
- Next state is EXEC.
REQ-013 EXEC, ALU or shift ops: drive alu_cond/shifter_control/shift_amt from instr fields; result_en=1; psr_en=1 for ALU ops only.
- src_b=1 for register form; 0 for immediate form.
- Next state is WB.
REQ-014 EXEC, LOAD/STOR: next state is MEM.
REQ-015 EXEC, branch, jump and JAL:
- Taken: pc_en=1 with branch_en, jump_en or jal_en asserted; pc_instruction=1 for branches only.
- JAL additionally sets result_en=1, choose_result=2'b11, then goes to WB.
- All other cases go to FETCH.
REQ-016 MEM: mem_req=1 and update_address=0; mem_we=1 for STOR.
- Holds until mem_ready=1.
- Then LOAD goes to WB with write_data=0; STOR goes to FETCH.
REQ-017 WB: reg_write=1 for exactly one cycle, then go to FETCH.
REQ-018 Every enable not explicitly asserted in a state SHALL be 0.
- Enables SHALL never be asserted while waiting on mem_ready.
REQ-019 Undefined opcode SHALL be treated as NOP: EXEC goes straight to FETCH with no enables.
REQ-020 Latency in cycles, with mem_ready=1 at first request:
- ALU: 4.
- LOAD: 5.
- STOR: 4.
- Branch: 3.
- JAL: 4.
REQ-021 Illegal state encodings SHALL return to FETCH on the next edge.

Reset
REQ-022 reset=1 at a clock edge SHALL force state=FETCH and all outputs to 0 on that edge, including mid-MEM and mid-WB.
- No reg_write, pc_en or mem_we pulse SHALL follow.
REQ-023 reset SHALL take priority over mem_ready in the same cycle.

Configuration
REQ-024 Macro CONTROLLER_FSM_COND_BRANCH_EN.
- Defined: branches and Jcond are evaluated against psr per the package condition table (EQ, NE, CS, CC, GT, LE, UC).
- Undefined: only UC is taken; every other condition is not taken; psr is ignored.

Structure
REQ-025 The shared package SHALL hold:
- State enum.
- Opcode and extended-opcode constants.
- PSR bit positions (C, L, F, Z, N).
- Condition-code constants.
- choose_result encodings.
REQ-026 One sub-module SHALL be instantiated: cond_eval, which maps psr and a 4-bit condition to a taken flag.

Verification
REQ-027 Reset then ADD R1,R2 with mem_ready=1:
- State sequence FETCH, DECODE, EXEC, WB, FETCH.
- reg_write pulses exactly once, in WB.
- psr_en pulses exactly once, in EXEC.
REQ-028 LOAD with mem_ready held 0 for 3 cycles in MEM:
- mem_req stays 1 for all 4 MEM cycles.
- reg_write is asserted only after mem_ready=1.
REQ-029 BEQ with psr Z=1: pc_en=1 and branch_en=1 in EXEC. BEQ with Z=0: pc_en=0 in EXEC. Both return to FETCH.
REQ-030 With the macro undefined, BEQ with Z=1 is not taken, and UC is taken.
REQ-031 reset asserted during STOR in MEM:
- mem_we=0 from that edge onward.
- state=FETCH.
- No writeback occurs.
REQ-032 Forcing state to 3'b111 returns the FSM to FETCH after one edge with all outputs 0.
